timer_array: RTL

Multi-channel, parametrised programmable interval timer for the MIPS system bus. It is the successor to the single-channel timer. It provides CHANNELS independent down-counters of WIDTH bits, each with:
- a per-channel clock prescaler,
- one-shot or periodic mode,
- a sticky write-1-to-clear interrupt-pending flag.

All channels share one register window and one combined interrupt line to the CP0 interrupt input.

---
 rtl/timer_array_if.sv | 34 +++
 rtl/timer_array.sv | 136 +++++++++++++
 2 files changed

// File: rtl/timer_array_if.sv
`default_nettype none
// ============================================================================
//  Module      : timer_array_if
//  Description : Register-window bus between a bus master and timer_array.
//                Word address, write strobe, write/read data and the combined
//                interrupt line.
//  Revision    : 1.0  initial release
// ============================================================================
interface timer_array_if #(
    parameter int ADDR_WIDTH = 3
);
    logic [ADDR_WIDTH-1:0] ADD_I;
    logic                  WE_I;
    logic [31:0]           DAT_I;
    logic [31:0]           DAT_O;
    logic                  IRQ_O;

    modport master (
        output ADD_I,
        output WE_I,
        output DAT_I,
        input  DAT_O,
        input  IRQ_O
    );

    modport slave (
        input  ADD_I,
        input  WE_I,
        input  DAT_I,
        output DAT_O,
        output IRQ_O
    );
endinterface
`default_nettype wire

// File: rtl/timer_array.sv
`default_nettype none
// ============================================================================
//  Module      : timer_array
//  Description : CHANNELS independent WIDTH-bit down-counters, each with a
//                PSC_WIDTH-bit prescaler, one-shot/periodic mode and a sticky
//                W1C pending flag. One register window, one combined IRQ.
//                Register map per channel: 0 CTRL, 1 PRESET, 2 COUNT, 3 STATUS.
//  Revision    : 1.0  initial release
// ============================================================================
module timer_array #(
    parameter int CHANNELS  = 2,
    parameter int WIDTH     = 32,
    parameter int PSC_WIDTH = 8
) (
    input  wire logic    CLK_I,
    input  wire logic    RST_I,
    timer_array_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(CHANNELS) + 2;
    localparam int SEL_WIDTH  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [SEL_WIDTH-1:0] ch_sel;
    logic                 ch_valid;
    logic [1:0]           reg_sel;
    logic [31:0]          rd_word [CHANNELS][4];
    logic [CHANNELS-1:0]  irq_vec;

    assign reg_sel = bus.ADD_I[1:0];

    generate
        if (CHANNELS > 1) begin : g_sel_multi
            assign ch_sel = bus.ADD_I[ADDR_WIDTH-1:2];
        end else begin : g_sel_single
            assign ch_sel = '0;
        end
    endgenerate

    // Address slots beyond the last channel (non power-of-two counts) are dead.
    assign ch_valid = (32'(ch_sel) < 32'(CHANNELS));

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic                 en;
            logic [1:0]           mode;
            logic                 im;
            logic [PSC_WIDTH-1:0] psc;
            logic [PSC_WIDTH-1:0] div;
            logic [WIDTH-1:0]     preset;
            logic [WIDTH-1:0]     count;
            logic                 pending;
            logic                 hit;
            logic                 wr_ctrl;
            logic                 wr_preset;
            logic                 wr_clear;
            logic                 tick;
            logic                 expire;

            assign hit       = bus.WE_I && ch_valid && (ch_sel == SEL_WIDTH'(gi));
            assign wr_ctrl   = hit && (reg_sel == 2'd0);
            assign wr_preset = hit && (reg_sel == 2'd1);
            assign wr_clear  = hit && (reg_sel == 2'd3) && bus.DAT_I[0];
            // A CTRL/PRESET write to this channel preempts its own tick.
            assign tick      = en && (div == psc) && !wr_ctrl && !wr_preset;
            assign expire    = tick && (count == '0);

            // Control, prescaler and counter state; bus writes win over ticks.
            always_ff @(posedge CLK_I or posedge RST_I) begin
                if (RST_I) begin
                    en     <= 1'b0;
                    mode   <= 2'b00;
                    im     <= 1'b0;
                    psc    <= '0;
                    div    <= '0;
                    preset <= '0;
                    count  <= '0;
                end else if (wr_ctrl) begin
                    en   <= bus.DAT_I[0];
                    mode <= bus.DAT_I[2:1];
                    im   <= bus.DAT_I[3];
                    psc  <= bus.DAT_I[4 +: PSC_WIDTH];
                    div  <= '0;
                end else if (wr_preset) begin
                    preset <= bus.DAT_I[WIDTH-1:0];
                    count  <= bus.DAT_I[WIDTH-1:0];
                    en     <= 1'b1;
                    div    <= '0;
                end else if (en) begin
                    if (div == psc) begin
                        div <= '0;
                        if (count == '0) begin
                            count <= preset;
                            // Only MODE=01 keeps running; 00 and 1x stop.
                            if (mode != 2'b01) begin
                                en <= 1'b0;
                            end
                        end else begin
                            count <= count - WIDTH'(1);
                        end
                    end else begin
                        div <= div + PSC_WIDTH'(1);
                    end
                end
            end

            // Sticky pending flag: an expiry beats a same-cycle W1C.
            always_ff @(posedge CLK_I or posedge RST_I) begin
                if (RST_I) begin
                    pending <= 1'b0;
                end else if (expire) begin
                    pending <= 1'b1;
                end else if (wr_clear) begin
                    pending <= 1'b0;
                end
            end

            assign rd_word[gi][0] = 32'({psc, im, mode, en});
            assign rd_word[gi][1] = 32'(preset);
            assign rd_word[gi][2] = 32'(count);
            assign rd_word[gi][3] = 32'(pending);
            assign irq_vec[gi]    = pending & im;
        end
    endgenerate

    // Combinational read of the addressed register; absent channels read zero.
    always_comb begin
        bus.DAT_O = '0;
        if (ch_valid) begin
            bus.DAT_O = rd_word[ch_sel][reg_sel];
        end
    end

    assign bus.IRQ_O = |irq_vec;

endmodule
`default_nettype wire
